// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch, execute-unit bursts
// and draw-unit sprite reads. One transaction at a time, fixed priority
// fetch > exec > draw, sampled only while idle. Read bytes come back through
// a one-deep capture pipeline aligned to the RAM's one-cycle read latency.
module mem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              resetN,

    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [15:0]       fetch_data,

    input  logic              ex_req,
    input  logic              ex_write,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [4:0]        ex_len,
    output logic [3:0]        ex_widx,
    input  logic [7:0]        ex_wdata,
    output logic              ex_rvalid,
    output logic [3:0]        ex_ridx,
    output logic [7:0]        ex_rdata,
    output logic              ex_done,

    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    input  logic [3:0]        dr_len,
    output logic              dr_rvalid,
    output logic [3:0]        dr_ridx,
    output logic [7:0]        dr_rdata,
    output logic              dr_done,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,

    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT     = 2'd2,
        S_COMPLETE = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_EXEC  = 2'd2;
    localparam logic [1:0] OWN_DRAW  = 2'd3;

    // Execute bursts never exceed one 16-register bank.
    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return (len > 5'd16) ? 5'd16 : len;
    endfunction

    state_t            state;
    logic              wr_q;
    logic [4:0]        len_q;
    logic [3:0]        k_q;
    logic [ADDR_W-1:0] base_q;

    logic              req_any;
    logic [1:0]        sel_owner;
    logic [ADDR_W-1:0] sel_base;
    logic [4:0]        sel_len;
    logic              sel_wr;
    logic              last_beat;
    logic              enter_cpl;
    logic [1:0]        cpl_owner;

    logic              vld_p0;
    logic [3:0]        idx_p0;
    logic [1:0]        own_p0;
    logic [7:0]        hold_p1;

    // Fixed-priority selection of the transaction that would start this cycle
    always_comb begin
        req_any   = fetch_req | ex_req | dr_req;
        sel_owner = OWN_NONE;
        sel_base  = '0;
        sel_len   = 5'd0;
        sel_wr    = 1'b0;
        if (fetch_req) begin
            sel_owner = OWN_FETCH;
            sel_base  = fetch_addr;
            sel_len   = 5'd2;
        end else if (ex_req) begin
            sel_owner = OWN_EXEC;
            sel_base  = ex_addr;
            sel_len   = clamp_len(ex_len);
            sel_wr    = ex_write;
        end else if (dr_req) begin
            sel_owner = OWN_DRAW;
            sel_base  = dr_addr;
            sel_len   = {1'b0, dr_len};
        end
    end

    // Detect the edge that moves the FSM into COMPLETE and who owns it
    always_comb begin
        last_beat = ({1'b0, k_q} == (len_q - 5'd1));
        enter_cpl = 1'b0;
        cpl_owner = grant;
        case (state)
            S_IDLE: begin
                enter_cpl = req_any && (sel_len == 5'd0);
                cpl_owner = sel_owner;
            end
            S_ISSUE:    enter_cpl = last_beat && wr_q;
            S_WAIT:     enter_cpl = 1'b1;
            default:    enter_cpl = 1'b0;
        endcase
    end

    // Write data is returned combinationally by the requester for the current index
    assign mem_wdata = mem_we ? ex_wdata : 8'd0;

    // Transaction FSM with registered RAM command, grant and completion pulses
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            grant     <= OWN_NONE;
            busy      <= 1'b0;
            wr_q      <= 1'b0;
            len_q     <= 5'd0;
            k_q       <= 4'd0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            ex_widx   <= 4'd0;
            fetch_ack <= 1'b0;
            ex_done   <= 1'b0;
            dr_done   <= 1'b0;
        end else begin
            fetch_ack <= enter_cpl && (cpl_owner == OWN_FETCH);
            ex_done   <= enter_cpl && (cpl_owner == OWN_EXEC);
            dr_done   <= enter_cpl && (cpl_owner == OWN_DRAW);
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        grant <= sel_owner;
                        busy  <= 1'b1;
                        wr_q  <= sel_wr;
                        len_q <= sel_len;
                        k_q   <= 4'd0;
                        if (sel_len == 5'd0) begin
                            state <= S_COMPLETE;
                        end else begin
                            state    <= S_ISSUE;
                            mem_addr <= sel_base;
                            mem_we   <= sel_wr;
                            ex_widx  <= 4'd0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_beat) begin
                        mem_addr <= '0;
                        mem_we   <= 1'b0;
                        ex_widx  <= 4'd0;
                        state    <= wr_q ? S_COMPLETE : S_WAIT;
                    end else begin
                        k_q      <= k_q + 4'd1;
                        mem_addr <= base_q + ADDR_W'(k_q) + ADDR_W'(1);
                        ex_widx  <= wr_q ? (k_q + 4'd1) : 4'd0;
                    end
                end
                S_WAIT: begin
                    state <= S_COMPLETE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    grant <= OWN_NONE;
                end
            endcase
        end
    end

    // Base address and first fetch byte are pure data and need no reset
    always_ff @(posedge clock) begin
        if (state == S_IDLE && req_any)
            base_q <= sel_base;
        if (vld_p0 && own_p0 == OWN_FETCH && idx_p0 == 4'd0)
            hold_p1 <= mem_rdata;
    end

    // Read capture: p0 marks a cycle in which mem_rdata answers last cycle's address
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            vld_p0     <= 1'b0;
            idx_p0     <= 4'd0;
            own_p0     <= OWN_NONE;
            ex_rvalid  <= 1'b0;
            ex_ridx    <= 4'd0;
            ex_rdata   <= 8'd0;
            dr_rvalid  <= 1'b0;
            dr_ridx    <= 4'd0;
            dr_rdata   <= 8'd0;
            fetch_data <= 16'd0;
        end else begin
            // stage p0: read address issued this cycle
            vld_p0 <= (state == S_ISSUE) && !wr_q;
            idx_p0 <= k_q;
            own_p0 <= grant;
            // stage p1: byte registered toward its requester
            ex_rvalid <= vld_p0 && (own_p0 == OWN_EXEC);
            ex_ridx   <= (vld_p0 && own_p0 == OWN_EXEC) ? idx_p0 : 4'd0;
            ex_rdata  <= (vld_p0 && own_p0 == OWN_EXEC) ? mem_rdata : 8'd0;
            dr_rvalid <= vld_p0 && (own_p0 == OWN_DRAW);
            dr_ridx   <= (vld_p0 && own_p0 == OWN_DRAW) ? idx_p0 : 4'd0;
            dr_rdata  <= (vld_p0 && own_p0 == OWN_DRAW) ? mem_rdata : 8'd0;
            if (vld_p0 && own_p0 == OWN_FETCH && idx_p0 == 4'd1)
                fetch_data <= {hold_p1, mem_rdata};
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width; all addresses wrap modulo 2^ADDR_W.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 resetN  in  1  asynchronous active-low reset.
REQ-005 fetch_req in 1, fetch_addr in ADDR_W: 2-byte instruction fetch request and base address.
REQ-006 fetch_ack out 1, fetch_data out 16: one-cycle completion pulse and {byte[addr], byte[addr+1]}.
REQ-007 ex_req in 1, ex_write in 1, ex_addr in ADDR_W, ex_len in 5: execute-unit burst (Fx55/Fx65) request; write flag, base, length.
REQ-008 ex_widx out 4, ex_wdata in 8: index of the byte being written; requester returns that byte combinationally.
REQ-009 ex_rvalid out 1, ex_ridx out 4, ex_rdata out 8, ex_done out 1: read-byte strobe, index, data; completion pulse.
REQ-010 dr_req in 1, dr_addr in ADDR_W, dr_len in 4: draw-unit sprite read request.
REQ-011 dr_rvalid out 1, dr_ridx out 4, dr_rdata out 8, dr_done out 1: sprite byte strobe, index, data; completion pulse.
REQ-012 mem_addr out ADDR_W, mem_we out 1, mem_wdata out 8: single-port RAM command.
REQ-013 mem_rdata in 8: RAM read data, valid the cycle after mem_addr is presented with mem_we=0.
REQ-014 busy out 1, grant out 2: transaction active; owner (0 none, 1 fetch, 2 exec, 3 draw).

Function
REQ-015 States: IDLE, ISSUE, WAIT, COMPLETE; grant sampled only in IDLE; no preemption.
REQ-016 Fixed priority among requests high in IDLE: fetch > exec > draw.
REQ-017 Grant cycle T (IDLE): latch owner, base, length N, direction; next state ISSUE, or COMPLETE if N=0.
REQ-018 Fetch length fixed N=2; ex_len values 17..31 clamped to 16; dr_len 0..15 used as-is.
REQ-019 ISSUE, cycles T+1..T+N: mem_addr = base+k (k=0..N-1, wrapping), one address per cycle, no gaps.
REQ-020 Write burst: mem_we=1, ex_widx=k, mem_wdata=ex_wdata each ISSUE cycle; then COMPLETE at T+N+1.
REQ-021 Read burst: mem_we=0; ISSUE -> WAIT (T+N+1) -> COMPLETE (T+N+2).
REQ-022 Read byte k registered from mem_rdata; ex_/dr_rvalid=1, ridx=k, rdata=byte visible in cycle T+3+k.
REQ-023 Fetch: fetch_data updated and fetch_ack pulsed in cycle T+4; fetch produces no rvalid strobes.
REQ-024 COMPLETE: owner's done/ack high exactly one cycle (coincides with last rvalid on reads); next state IDLE.
REQ-025 N=0: done pulse at T+1, no mem_addr/mem_we activity.
REQ-026 Requester holds req, addr, len and write stable from assertion until its done/ack; it deasserts req on the edge ending the done cycle; req high in IDLE starts a new transaction.
REQ-027 Outside ISSUE: mem_we=0, mem_addr=0, mem_wdata=0; rvalid/done/ack=0 except as above.
REQ-028 busy=1 and grant=owner in all states except IDLE.
REQ-029 Address wrap: base+k computed modulo 2^ADDR_W (0xFFF+1 -> 0x000).

Reset
REQ-030 resetN low: immediately (asynchronously) state=IDLE, grant=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, all rvalid/ridx/rdata/done/ack/fetch_data/ex_widx=0.
REQ-031 Reset mid-transaction aborts it silently (no done/ack); a request still held after release is re-granted from k=0.

Verification
REQ-032 RAM[0x200..0x201]=0x12,0x4E; fetch_req, fetch_addr=0x200 -> mem_addr 0x200,0x201 at T+1,T+2; fetch_ack at T+4; fetch_data=0x124E; mem_we never 1.
REQ-033 Exec write, ex_addr=0x3E8, ex_len=16, ex_wdata=0x11*ex_widx -> mem_we=1 at T+1..T+16, addresses 0x3E8..0x3F7, data 0x00..0xFF; ex_done at T+17.
REQ-034 RAM[0..4]=F0 90 90 90 F0; dr_addr=0, dr_len=5 -> dr_rvalid T+3..T+7, ridx 0..4, data F0 90 90 90 F0; dr_done at T+7.
REQ-035 fetch_req, ex_req (len 1, read), dr_req (len 1) rise together -> grant 1, then 2, then 3; no overlapping ISSUE cycles; each done exactly once.
REQ-036 fetch_addr=0xFFF -> mem_addr 0xFFF then 0x000; fetch_data={RAM[0xFFF],RAM[0x000]}; ex_len=0 -> ex_done at T+1, no RAM access.
REQ-037 resetN low at k=5 of a 16-byte write -> mem_we=0 same cycle, all outputs 0, no ex_done; after release, held ex_req restarts at ex_addr, k=0.
